// File: rtl/vadd_sequencer.sv
// vadd_sequencer: steps one vector-add instruction through a shared 24-bit
// floating-point adder (sign[23], mantissa[22:8], exponent[7:0]).
//
// Three-stage pipeline. An element is read in cycle k, the operands are
// registered in k+1, the sum is registered in k+2, and it is written in k+3.
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   start, vlen, *_base           launch; vlen and bases are sampled in IDLE
//   stall                         freezes the pipeline, counters and FSM
//   rd_en, rd_addr_a/b, rd_data_* register-file read port (data one cycle later)
//   add_data_1/2, add_sum         adder operands (registered) and adder result
//   wr_en, wr_addr, wr_data       register-file write port
//   busy, done, ovf, sign_err     status; ovf and sign_err are sticky until start
module vadd_sequencer #(
  parameter int WORD_SIZE = 24,
  parameter int ADDR_W    = 8,
  parameter int VLEN_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VLEN_W-1:0]    vlen,
  input  logic [ADDR_W-1:0]    src_a_base,
  input  logic [ADDR_W-1:0]    src_b_base,
  input  logic [ADDR_W-1:0]    dst_base,
  input  logic                 stall,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr_a,
  output logic [ADDR_W-1:0]    rd_addr_b,
  input  logic [WORD_SIZE-1:0] rd_data_a,
  input  logic [WORD_SIZE-1:0] rd_data_b,
  output logic [WORD_SIZE-1:0] add_data_1,
  output logic [WORD_SIZE-1:0] add_data_2,
  input  logic [WORD_SIZE-1:0] add_sum,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 sign_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                state_q, state_d;
  logic [VLEN_W-1:0]     idx_q, idx_d, vlen_q, vlen_d;
  logic [ADDR_W-1:0]     a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
  // Stage 0: a read is outstanding; its data arrives in this cycle.
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]     dst_p_q, dst_p_d;
  // Skid: holds read data that arrived while stall was high.
  logic                  skid_vld_q, skid_vld_d;
  logic [WORD_SIZE-1:0]  skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  // Stage 1: adder operands.
  logic                  v1_q, v1_d;
  logic [WORD_SIZE-1:0]  add1_q, add1_d, add2_q, add2_d;
  logic [ADDR_W-1:0]     dst1_q, dst1_d;
  // Stage 2: registered sum waiting to be written.
  logic                  v2_q, v2_d;
  logic [WORD_SIZE-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  ovf_q, ovf_d, sign_q, sign_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vlen_d     = vlen_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    d_base_d   = d_base_q;
    rd_pend_d  = 1'b0;
    dst_p_d    = dst_p_q;
    skid_vld_d = skid_vld_q;
    skid_a_d   = skid_a_q;
    skid_b_d   = skid_b_q;
    v1_d       = v1_q;
    add1_d     = add1_q;
    add2_d     = add2_q;
    dst1_d     = dst1_q;
    v2_d       = v2_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    ovf_d      = ovf_q;
    sign_d     = sign_q;

    case (state_q)
      IDLE: if (start) begin
        vlen_d   = vlen;
        a_base_d = src_a_base;
        b_base_d = src_b_base;
        d_base_d = dst_base;
        idx_d    = '0;
        ovf_d    = 1'b0;
        sign_d   = 1'b0;
        state_d  = (vlen != '0) ? RUN : FIN;
      end
      RUN: if (!stall) begin
        rd_pend_d = 1'b1;
        dst_p_d   = d_base_q + ADDR_W'(idx_q);
        idx_d     = idx_q + VLEN_W'(1);
        if (idx_q == vlen_q - VLEN_W'(1)) state_d = DRAIN;
      end
      // Leave once the last element is in stage 2; its write happens this cycle.
      DRAIN: if (!stall && !rd_pend_q && !skid_vld_q && !v1_q) state_d = FIN;
      default: state_d = IDLE;
    endcase

    // Read data is only valid for one cycle, so catch it even under stall.
    if (rd_pend_q && stall) begin
      skid_vld_d = 1'b1;
      skid_a_d   = rd_data_a;
      skid_b_d   = rd_data_b;
    end

    if (!stall) begin
      v2_d = v1_q;
      if (v1_q) begin
        wr_data_d = add_sum;
        wr_addr_d = dst1_q;
        // Exponent wrap: an operand already at max exponent and the result wrapped to 0.
        if ((add1_q[7:0] == 8'hFF || add2_q[7:0] == 8'hFF) && add_sum[7:0] == 8'h00)
          ovf_d = 1'b1;
        if (add1_q[WORD_SIZE-1] || add2_q[WORD_SIZE-1]) sign_d = 1'b1;
      end
      v1_d = rd_pend_q || skid_vld_q;
      if (rd_pend_q) begin
        add1_d = rd_data_a;
        add2_d = rd_data_b;
        dst1_d = dst_p_q;
      end else if (skid_vld_q) begin
        add1_d     = skid_a_q;
        add2_d     = skid_b_q;
        dst1_d     = dst_p_q;
        skid_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      vlen_q     <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      d_base_q   <= '0;
      rd_pend_q  <= 1'b0;
      dst_p_q    <= '0;
      skid_vld_q <= 1'b0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      v1_q       <= 1'b0;
      add1_q     <= '0;
      add2_q     <= '0;
      dst1_q     <= '0;
      v2_q       <= 1'b0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vlen_q     <= vlen_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      d_base_q   <= d_base_d;
      rd_pend_q  <= rd_pend_d;
      dst_p_q    <= dst_p_d;
      skid_vld_q <= skid_vld_d;
      skid_a_q   <= skid_a_d;
      skid_b_q   <= skid_b_d;
      v1_q       <= v1_d;
      add1_q     <= add1_d;
      add2_q     <= add2_d;
      dst1_q     <= dst1_d;
      v2_q       <= v2_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      ovf_q      <= ovf_d;
      sign_q     <= sign_d;
    end
  end

  assign rd_en      = (state_q == RUN) && !stall;
  assign rd_addr_a  = a_base_q + ADDR_W'(idx_q);
  assign rd_addr_b  = b_base_q + ADDR_W'(idx_q);
  assign add_data_1 = add1_q;
  assign add_data_2 = add2_q;
  assign wr_en      = v2_q && !stall;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == FIN);
  assign ovf        = ovf_q;
  assign sign_err   = sign_q;

endmodule

// File: tb/tb_vadd_sequencer.sv
// Bench for vadd_sequencer: register-file and adder models, a read/write
// scoreboard (expected addresses, data and write cycles) and directed tests.
module tb_vadd_sequencer;
  localparam int W = 24, AW = 8, VW = 6;

  logic          clk, rst, start, stall;
  logic [VW-1:0] vlen;
  logic [AW-1:0] src_a_base, src_b_base, dst_base;
  logic          rd_en, wr_en, busy, done, ovf, sign_err;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [W-1:0]  rd_data_a, rd_data_b, add_data_1, add_data_2, add_sum, wr_data;

  vadd_sequencer #(.WORD_SIZE(W), .ADDR_W(AW), .VLEN_W(VW)) dut (
    .clk(clk), .rst(rst), .start(start), .vlen(vlen),
    .src_a_base(src_a_base), .src_b_base(src_b_base), .dst_base(dst_base),
    .stall(stall), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .add_data_1(add_data_1), .add_data_2(add_data_2), .add_sum(add_sum),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ovf(ovf), .sign_err(sign_err));

  int checks = 0, fails = 0, cyc = 0;
  logic [W-1:0] mem [256];

  typedef struct {logic [AW-1:0] addr; logic [W-1:0] data; int cyc;} wexp_t;
  wexp_t        wq[$];
  logic [15:0]  rq[$];

  // Toy adder: add mantissas, renormalise by one, bump the larger exponent.
  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [15:0] m;
    logic [7:0]  e;
    m = {1'b0, a[22:8]} + {1'b0, b[22:8]};
    e = ((a[7:0] > b[7:0]) ? a[7:0] : b[7:0]) + 8'd1;
    return {1'b0, m[15:1], e};
  endfunction

  assign add_sum = fadd(add_data_1, add_data_2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Register-file read port: data valid only in the cycle after rd_en, junk otherwise.
  initial begin
    logic p;
    logic [AW-1:0] aa, bb;
    rd_data_a = '0; rd_data_b = '0;
    forever begin
      @(negedge clk);
      p = rd_en; aa = rd_addr_a; bb = rd_addr_b;
      @(posedge clk); #1;
      rd_data_a = p ? mem[aa] : W'($urandom);
      rd_data_b = p ? mem[bb] : W'($urandom);
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [15:0] e;
    wexp_t w;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        if (rq.size() == 0) chk("rd_unexpected", 32'(rd_en), 32'd0);
        else begin
          e = rq.pop_front();
          chk("rd_addr_a", 32'(rd_addr_a), 32'(e[15:8]));
          chk("rd_addr_b", 32'(rd_addr_b), 32'(e[7:0]));
        end
      end
      if (wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(w.addr));
          chk("wr_data", 32'(wr_data), 32'(w.data));
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic launch(input int n, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, input int dly, output int t0);
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      rq.push_back({AW'(a + i), AW'(b + i)});
      wq.push_back('{addr: AW'(d + i), data: fadd(mem[AW'(a + i)], mem[AW'(b + i)]),
                     cyc: t0 + 4 + i + dly});
    end
    vlen = VW'(n); src_a_base = a; src_b_base = b; dst_base = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_c, input int slo, input int shi, input bit mid);
    int c;
    bit got;
    got = 1'b0;
    for (c = 1; c <= 60; c++) begin
      stall = (c >= slo && c <= shi);
      start = mid && (c == 2);
      if (mid && c == 2) begin
        vlen = 6'd3; src_a_base = 8'h50; src_b_base = 8'h60; dst_base = 8'h70;
      end
      if (c == 1) chk("busy_c1", 32'(busy), 32'(exp_c != 1));
      if (done) begin got = 1'b1; break; end
      tick();
    end
    stall = 1'b0; start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("done_cycle", 32'(c), 32'(exp_c));
    chk("busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("rq_left", 32'(rq.size()), 32'd0);
    chk("wq_left", 32'(wq.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_flags"}, 32'({ovf, sign_err}), 32'd0);
    chk({tag, "_add"}, 32'(add_data_1 | add_data_2), 32'd0);
    chk({tag, "_wr"}, 32'(wr_data | W'(wr_addr)), 32'd0);
    chk({tag, "_rdaddr"}, 32'({rd_addr_a, rd_addr_b}), 32'd0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; stall = 1'b0; vlen = '0;
    src_a_base = '0; src_b_base = '0; dst_base = '0;
    for (int i = 0; i < 256; i++) mem[i] = W'(24'h400010 + (i % 16) * 24'h100);
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Basic run: writes 32..35 in cycles 4..7, done in 8.
    for (int i = 0; i < 4; i++) begin
      mem[i]      = W'(24'h400010 + i * 24'h100);
      mem[16 + i] = W'(24'h400010 + i * 24'h300);
    end
    chk("model_sum0", 32'(fadd(mem[0], mem[16])), 32'h400011);
    launch(4, 8'd0, 8'd16, 8'd32, 0, t0);
    wait_done(8, 0, 0, 1'b0);

    // Empty vector.
    launch(0, 8'd0, 8'd0, 8'd0, 0, t0);
    wait_done(1, 0, 0, 1'b0);
    repeat (2) tick();
    chk("vlen0_busy_after", 32'(busy), 32'd0);

    // Stall in cycles 2..4 shifts every write by three cycles.
    launch(5, 8'd64, 8'd96, 8'd128, 3, t0);
    wait_done(12, 2, 4, 1'b0);

    // Exponent overflow, sticky through done.
    mem[200] = 24'h4000FF; mem[210] = 24'h4000FF;
    mem[201] = 24'h400020; mem[211] = 24'h400020;
    launch(2, 8'd200, 8'd210, 8'd220, 0, t0);
    wait_done(6, 0, 0, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_no_sign", 32'(sign_err), 32'd0);

    // Sign error; the new start clears ovf.
    mem[230] = 24'h800005; mem[231] = 24'h000005;
    launch(1, 8'd230, 8'd231, 8'd232, 0, t0);
    chk("ovf_cleared", 32'(ovf), 32'd0);
    wait_done(5, 0, 0, 1'b0);
    chk("sign_err_set", 32'(sign_err), 32'd1);
    chk("sign_no_ovf", 32'(ovf), 32'd0);

    // Address wrap on read and write; start pulsed mid-run is ignored.
    mem[8'hFE] = 24'h410012; mem[8'hFF] = 24'h420013;
    mem[8'h00] = 24'h430014; mem[8'h01] = 24'h440015;
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = W'(24'h100010 + i * 24'h10100);
    launch(4, 8'hFE, 8'h10, 8'hFE, 0, t0);
    wait_done(8, 0, 0, 1'b1);
    repeat (3) tick();
    chk("mid_start_idle", 32'(busy), 32'd0);

    // Reset in cycle 3 of vlen=8 aborts; nothing else is written.
    launch(8, 8'd40, 8'd48, 8'd56, 0, t0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rq.delete(); wq.delete();
    chk_zero("abort");
    rst = 1'b0;
    repeat (8) tick();
    chk("abort_idle", 32'(busy), 32'd0);

    // Normal run after abort.
    launch(3, 8'd40, 8'd48, 8'd60, 0, t0);
    wait_done(7, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vadd_sequencer.md
Name: vadd_sequencer

Overview:
- Sequences one vector add instruction through the shared 24-bit floating-point adder (sign[23], mantissa[22:8], exponent[7:0]).
- Reads element pairs from the vector register file, drives the adder operands, and writes each sum back.
- Runs as a 3-stage pipeline, one element per cycle when not stalled.
- Sits between the vector issue logic and the register file / adder.

Parameters:
- WORD_SIZE, 24, element width; must match the adder.
- ADDR_W, 8, register-file element address width.
- VLEN_W, 6, vector length field width.

Ports:
- clk  input  1  clock; everything updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle launch pulse; accepted only in IDLE.
- vlen  input  VLEN_W  element count, sampled on accepted start.
- src_a_base  input  ADDR_W  base address of operand A, sampled on start.
- src_b_base  input  ADDR_W  base address of operand B, sampled on start.
- dst_base  input  ADDR_W  base address of result, sampled on start.
- stall  input  1  freezes the whole pipeline and the counters while high.
- rd_en  output  1  register-file read strobe.
- rd_addr_a  output  ADDR_W  operand A read address.
- rd_addr_b  output  ADDR_W  operand B read address.
- rd_data_a  input  WORD_SIZE  operand A data, valid the cycle after rd_en.
- rd_data_b  input  WORD_SIZE  operand B data, valid the cycle after rd_en.
- add_data_1  output  WORD_SIZE  registered adder operand 1.
- add_data_2  output  WORD_SIZE  registered adder operand 2.
- add_sum  input  WORD_SIZE  combinational adder result.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  WORD_SIZE  registered sum.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle completion pulse.
- ovf  output  1  sticky exponent-overflow flag.
- sign_err  output  1  sticky flag: an operand had sign bit set.

Behaviour:
- Reset: state IDLE. All outputs 0, all counters 0, ovf=0, sign_err=0. Reset in any state aborts at once; no further rd_en or wr_en.
- States and transitions:
  - IDLE: on start, latch bases and vlen, clear ovf and sign_err, set busy=1. If vlen!=0 go to RUN, else go to FIN.
  - RUN: issue element i with rd_en=1, rd_addr_a=src_a_base+i, rd_addr_b=src_b_base+i; increment i. After issuing element vlen-1 go to DRAIN.
  - DRAIN: no reads; wait until both pipeline valid bits are 0, then go to FIN.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Pipeline, for element i read in cycle k:
  - Cycle k+1: rd_data captured into add_data_1/add_data_2; stage-1 valid set.
  - Cycle k+2: add_sum captured into wr_data, wr_addr=dst_base+i.
  - Cycle k+3: wr_en=1.
  - Read-to-write latency is 3 cycles. Unstalled, vlen=N takes cycles 1..N for reads, writes land in cycles 4..N+3, done in cycle N+4 (start accepted in cycle 0).
- stall=1: rd_en=0, wr_en=0, all pipeline registers, valid bits and counters hold. A read issued in the cycle before stall rises keeps its data captured: stage 0 captures rd_data regardless of stall, held in a skid register. Nothing is duplicated or lost.
- Address arithmetic is modulo 2^ADDR_W (wrap-around permitted).
- ovf: set when a stage-1 element has max(exp1,exp2)==8'hFF and add_sum[7:0]==8'h00 (adder exponent wrap). sign_err: set when either captured operand has bit [WORD_SIZE-1]=1. Both hold until the next accepted start.
- No outputs are combinational from inputs except through registers.

Test Plan:
- vlen=4, A=B=base 0/16, dst 32, data A={0x400010,…}, B={0x400010,…} -> writes to 32..35 in cycles 4..7; wr_data 0x400011 (mantissa carry, exp+1); done in cycle 8.
- vlen=0 start -> no rd_en/wr_en, done pulse cycle 1, busy low after.
- vlen=5 with stall held high for cycles 2–4 -> same 5 writes, same data and addresses, each delayed 3 cycles; no duplicate or missing writes.
- Operand pair exp=0xFF with mantissa carry -> ovf=1 stays set through done, cleared by next start. Operand 0x800005 -> sign_err=1.
- src_a_base=0xFE, vlen=4 -> rd_addr_a sequence FE, FF, 00, 01. start pulsed mid-run is ignored.
- rst asserted in cycle 3 of vlen=8 -> next cycle all outputs 0, no further writes; a new start then runs normally.
